aes_job_sequencer: RTL and testbench

AES_JOB_SEQUENCER -- requirements
Module: aes_job_sequencer

---
 rtl/aes_ctrl_pkg.sv | 16 +
 rtl/aes_byte_ser.sv | 25 ++
 rtl/aes_job_sequencer.sv | 152 +++++++++++++++
 tb/tb_aes_job_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared engine command codes and sequencer state encoding for the AES job sequencer.
package aes_ctrl_pkg;

   localparam logic [1:0] CMD_IDLE    = 2'b00;
   localparam logic [1:0] CMD_SET_PT  = 2'b01;
   localparam logic [1:0] CMD_SET_KEY = 2'b10;
   localparam logic [1:0] CMD_START   = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_PT,
      LOAD_KEY,
      WAIT_DONE
   } seq_state_e;

endpackage

// File: rtl/aes_byte_ser.sv
// 128-bit load-and-shift register presenting its most significant byte; shared by
// the plaintext and key load phases.
module aes_byte_ser (
   input  logic         clk,
   input  logic         rst_,
   input  logic         load,
   input  logic         shift,
   input  logic [127:0] din,
   output logic [7:0]   byte_q
);

   logic [127:0] sr;

   always_ff @(posedge clk) begin
      if (rst_)
         sr <= '0;
      else if (load)
         sr <= din;
      else if (shift)
         sr <= {sr[119:0], 8'h00};
   end

   assign byte_q = sr[127:120];

endmodule

// File: rtl/aes_job_sequencer.sv
// Accepts one AES job, streams plaintext then key bytewise to the engine, starts it and
// waits for done or timeout. Optional key cache: define AES_SEQ_KEY_CACHE_EN.
module aes_job_sequencer
   import aes_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [127:0] req_pt,
   input  logic [127:0] req_key,
   output logic         busy,
   output logic         job_done,
   output logic         job_err,
   output logic [1:0]   eng_cmd,
   output logic [7:0]   eng_din,
   input  logic         eng_ready,
   input  logic         eng_done
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   seq_state_e   state;
   logic [3:0]   byte_cnt;
   logic [15:0]  wait_cnt;
   logic [127:0] key_q;
   logic         din_en;
   logic         accept;
   logic         timeout_hit;
   logic         skip_key;
   logic         ser_load;
   logic         ser_shift;
   logic [127:0] ser_din;
   logic [7:0]   ser_byte;

   assign req_ready   = (state == IDLE) & eng_ready & ~rst_;
   assign accept      = req_valid & req_ready;
   assign timeout_hit = (state == WAIT_DONE) & ~eng_done & (wait_cnt == WAIT_LAST);

   // The serializer is loaded with the plaintext on accept and reloaded with the key
   // during the last plaintext byte, so the key's first byte follows without a gap.
   assign ser_load  = accept | ((state == LOAD_PT) & (byte_cnt == 4'd15));
   assign ser_din   = accept ? req_pt : key_q;
   assign ser_shift = ((state == LOAD_PT) | (state == LOAD_KEY)) & ~ser_load;
   assign eng_din   = din_en ? ser_byte : 8'h00;

   aes_byte_ser u_ser (
      .clk    (clk),
      .rst_   (rst_),
      .load   (ser_load),
      .shift  (ser_shift),
      .din    (ser_din),
      .byte_q (ser_byte)
   );

   always_ff @(posedge clk) begin
      if (rst_) begin
         state    <= IDLE;
         byte_cnt <= 4'd0;
         wait_cnt <= 16'd0;
         key_q    <= '0;
         din_en   <= 1'b0;
         eng_cmd  <= CMD_IDLE;
         busy     <= 1'b0;
         job_done <= 1'b0;
         job_err  <= 1'b0;
      end else begin
         job_done <= 1'b0;
         job_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  key_q    <= req_key;
                  byte_cnt <= 4'd0;
                  din_en   <= 1'b1;
                  busy     <= 1'b1;
                  eng_cmd  <= CMD_SET_PT;
                  state    <= LOAD_PT;
               end
            end
            LOAD_PT: begin
               byte_cnt <= byte_cnt + 4'd1;
               if (byte_cnt == 4'd15) begin
                  if (skip_key) begin
                     din_en   <= 1'b0;
                     wait_cnt <= 16'd0;
                     eng_cmd  <= CMD_START;
                     state    <= WAIT_DONE;
                  end else begin
                     eng_cmd <= CMD_SET_KEY;
                     state   <= LOAD_KEY;
                  end
               end
            end
            LOAD_KEY: begin
               byte_cnt <= byte_cnt + 4'd1;
               if (byte_cnt == 4'd15) begin
                  din_en   <= 1'b0;
                  wait_cnt <= 16'd0;
                  eng_cmd  <= CMD_START;
                  state    <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               // Done is checked first so it wins over a coincident timeout.
               if (eng_done) begin
                  job_done <= 1'b1;
                  busy     <= 1'b0;
                  eng_cmd  <= CMD_IDLE;
                  state    <= IDLE;
               end else if (timeout_hit) begin
                  job_err  <= 1'b1;
                  busy     <= 1'b0;
                  eng_cmd  <= CMD_IDLE;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AES_SEQ_KEY_CACHE_EN
   logic [127:0] cache_key;
   logic         cache_vld;

   // Cache holds the last key that was streamed completely; a timeout distrusts it.
   always_ff @(posedge clk) begin
      if (rst_) begin
         cache_key <= '0;
         cache_vld <= 1'b0;
         skip_key  <= 1'b0;
      end else begin
         if (accept)
            skip_key <= cache_vld & (req_key == cache_key);
         if ((state == LOAD_KEY) & (byte_cnt == 4'd15)) begin
            cache_key <= key_q;
            cache_vld <= 1'b1;
         end else if (timeout_hit) begin
            cache_vld <= 1'b0;
         end
      end
   end
`else
   assign skip_key = 1'b0;
`endif

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Randomized bench: two sequencers (long and short timeout) checked every cycle against
// a job-timeline reference model that predicts each output from accept time and engine plan.
module tb_aes_job_sequencer;

   localparam int TO0 = 1023;
   localparam int TO1 = 8;
`ifdef AES_SEQ_KEY_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   localparam logic [127:0] PT_NOM  = 128'h00041214120412000C00131108231919;
   localparam logic [127:0] KEY_NOM = 128'h2475A2B33475568831E2120013AA5487;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_[2], req_valid[2], eng_ready[2], eng_done[2];
   logic [127:0] req_pt[2], req_key[2];
   logic         req_ready[2], busy[2], job_done[2], job_err[2];
   logic [1:0]   eng_cmd[2];
   logic [7:0]   eng_din[2];

   aes_job_sequencer u_dut0 (
      .clk(clk), .rst_(rst_[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_pt(req_pt[0]), .req_key(req_key[0]), .busy(busy[0]), .job_done(job_done[0]),
      .job_err(job_err[0]), .eng_cmd(eng_cmd[0]), .eng_din(eng_din[0]),
      .eng_ready(eng_ready[0]), .eng_done(eng_done[0])
   );

   aes_job_sequencer #(.TIMEOUT_CYCLES(TO1)) u_dut1 (
      .clk(clk), .rst_(rst_[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_pt(req_pt[1]), .req_key(req_key[1]), .busy(busy[1]), .job_done(job_done[1]),
      .job_err(job_err[1]), .eng_cmd(eng_cmd[1]), .eng_din(eng_din[1]),
      .eng_ready(eng_ready[1]), .eng_done(eng_done[1])
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   bit known = 1'b0;
   bit rnd = 1'b0;

   // stimulus intent
   logic         v_valid[2], v_ready[2], v_rst[2];
   logic [127:0] v_pt[2], v_key[2];
   int           plan_dk[2];
   bit           plan_rmid[2];
   logic [127:0] key_pool[2];

   // reference model: one job timeline per instance
   int           to_cyc[2];
   bit           act[2], fin_err[2], cache_vld[2];
   int           t0[2], ws[2], fin[2], done_cyc[2], rst_at[2];
   logic [127:0] pt_m[2], key_m[2], cache_key[2];
   int           mdl_done[2], mdl_err[2], obs_done[2], obs_err[2];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // {req_ready, busy, job_done, job_err, eng_cmd, eng_din}
   function automatic logic [13:0] expect_vec(int i);
      logic       rr, bz, dn, er;
      logic [1:0] cmd;
      logic [7:0] din;
      int         k;
      rr = 1'b0; bz = 1'b0; dn = 1'b0; er = 1'b0; cmd = 2'b00; din = 8'h00;
      if (act[i] && cyc < ws[i]) begin
         k  = cyc - t0[i] - 1;
         bz = 1'b1;
         if (k < 16) begin
            cmd = 2'b01;
            din = pt_m[i][127 - 8*k -: 8];
         end else begin
            cmd = 2'b10;
            din = key_m[i][127 - 8*(k-16) -: 8];
         end
      end else if (act[i] && cyc < fin[i]) begin
         bz  = 1'b1;
         cmd = 2'b11;
      end else if (act[i] && cyc == fin[i]) begin
         dn = ~fin_err[i];
         er = fin_err[i];
      end
      rr = ~bz & eng_ready[i] & ~rst_[i];
      return {rr, bz, dn, er, cmd, din};
   endfunction

   task automatic tick();
      bit in_wait, hit;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rnd) begin
            v_valid[i]   = ($urandom % 3) == 0;
            v_ready[i]   = ($urandom % 8) != 0;
            v_rst[i]     = ($urandom % 300) == 0;
            v_pt[i]      = {$urandom, $urandom, $urandom, $urandom};
            v_key[i]     = (($urandom % 4) == 0) ? {$urandom, $urandom, $urandom, $urandom}
                                                 : key_pool[$urandom % 2];
            plan_dk[i]   = (i == 0) ? $urandom_range(1, 50) : $urandom_range(1, 12);
            plan_rmid[i] = 1'b0;
         end
         rst_[i]      = v_rst[i] | (act[i] && cyc == rst_at[i]);
         req_valid[i] = v_valid[i];
         eng_ready[i] = v_ready[i];
         req_pt[i]    = v_pt[i];
         req_key[i]   = v_key[i];
         in_wait      = act[i] && cyc >= ws[i] && cyc < fin[i];
         eng_done[i]  = in_wait ? (cyc == done_cyc[i]) : (($urandom % 4) == 0);
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         if (known) begin
            check_val(i == 0 ? "dut0" : "dut1",
                      {18'd0, req_ready[i], busy[i], job_done[i], job_err[i], eng_cmd[i], eng_din[i]},
                      {18'd0, expect_vec(i)});
            obs_done[i] += int'(job_done[i] === 1'b1);
            obs_err[i]  += int'(job_err[i] === 1'b1);
         end
         if (act[i] && cyc == fin[i]) begin
            if (fin_err[i]) begin
               mdl_err[i]++;
               cache_vld[i] = 1'b0;
            end else begin
               mdl_done[i]++;
            end
            act[i] = 1'b0;
         end
         if (rst_[i]) begin
            act[i]       = 1'b0;
            cache_vld[i] = 1'b0;
         end else if (!act[i] && req_valid[i] && eng_ready[i]) begin
            hit        = CACHE_EN && cache_vld[i] && (req_key[i] == cache_key[i]);
            act[i]     = 1'b1;
            t0[i]      = cyc;
            pt_m[i]    = req_pt[i];
            key_m[i]   = req_key[i];
            ws[i]      = cyc + (hit ? 17 : 33);
            rst_at[i]  = plan_rmid[i] ? cyc + 8 : -1;
            if (plan_dk[i] <= to_cyc[i]) begin
               fin[i]      = ws[i] + plan_dk[i];
               fin_err[i]  = 1'b0;
               done_cyc[i] = ws[i] + plan_dk[i] - 1;
            end else begin
               fin[i]      = ws[i] + to_cyc[i];
               fin_err[i]  = 1'b1;
               done_cyc[i] = -1;
            end
            if (!hit) begin
               cache_key[i] = req_key[i];
               cache_vld[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic launch(input int i, input logic [127:0] pt, input logic [127:0] key,
                         input int dk, input bit rmid);
      v_pt[i]      = pt;
      v_key[i]     = key;
      plan_dk[i]   = dk;
      plan_rmid[i] = rmid;
      v_valid[i]   = 1'b1;
   endtask

   initial begin
      to_cyc[0] = TO0;
      to_cyc[1] = TO1;
      key_pool[0] = KEY_NOM;
      key_pool[1] = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      for (int i = 0; i < 2; i++) begin
         v_valid[i] = 1'b0; v_ready[i] = 1'b1; v_rst[i] = 1'b1;
         v_pt[i] = '0; v_key[i] = '0; plan_dk[i] = 1; plan_rmid[i] = 1'b0;
         act[i] = 1'b0; fin_err[i] = 1'b0; cache_vld[i] = 1'b0; cache_key[i] = '0;
         t0[i] = 0; ws[i] = 0; fin[i] = 0; done_cyc[i] = -1; rst_at[i] = -1;
         pt_m[i] = '0; key_m[i] = '0;
         mdl_done[i] = 0; mdl_err[i] = 0; obs_done[i] = 0; obs_err[i] = 0;
         rst_[i] = 1'b1; req_valid[i] = 1'b0; eng_ready[i] = 1'b1; eng_done[i] = 1'b0;
         req_pt[i] = '0; req_key[i] = '0;
      end

      // reset state
      tick();
      known = 1'b1;
      tick();
      v_rst[0] = 1'b0;
      v_rst[1] = 1'b0;
      ticks(2);

      // nominal job on dut0 (done 40 cycles after start), timeout on dut1
      launch(0, PT_NOM, KEY_NOM, 41, 1'b0);
      launch(1, PT_NOM, KEY_NOM, 1000, 1'b0);
      tick();
      v_valid[0] = 1'b0;
      v_valid[1] = 1'b0;
      ticks(90);

      // same key again on dut0; done and timeout coincide on dut1
      launch(0, ~PT_NOM, KEY_NOM, 5, 1'b0);
      launch(1, ~PT_NOM, KEY_NOM, TO1, 1'b0);
      tick();
      v_valid[0] = 1'b0;
      v_valid[1] = 1'b0;
      ticks(60);

      // reset at plaintext byte 7, then a clean job
      launch(0, PT_NOM, KEY_NOM, 3, 1'b1);
      launch(1, PT_NOM, key_pool[1], 3, 1'b1);
      tick();
      v_valid[0] = 1'b0;
      v_valid[1] = 1'b0;
      ticks(20);
      launch(0, PT_NOM, KEY_NOM, 3, 1'b0);
      launch(1, PT_NOM, key_pool[1], 3, 1'b0);
      tick();
      v_valid[0] = 1'b0;
      v_valid[1] = 1'b0;
      ticks(60);

      // back-pressure: request held while engine not ready
      v_ready[0] = 1'b0;
      v_ready[1] = 1'b0;
      launch(0, PT_NOM, key_pool[1], 2, 1'b0);
      launch(1, PT_NOM, KEY_NOM, 2, 1'b0);
      ticks(6);
      v_ready[0] = 1'b1;
      v_ready[1] = 1'b1;
      tick();
      v_valid[0] = 1'b0;
      v_valid[1] = 1'b0;
      ticks(60);

      // randomized traffic, then drain
      rnd = 1'b1;
      ticks(3000);
      rnd = 1'b0;
      for (int i = 0; i < 2; i++) begin
         v_valid[i] = 1'b0; v_ready[i] = 1'b1; v_rst[i] = 1'b0;
      end
      ticks(100);

      check_val("ndone0", obs_done[0], mdl_done[0]);
      check_val("nerr0",  obs_err[0],  mdl_err[0]);
      check_val("ndone1", obs_done[1], mdl_done[1]);
      check_val("nerr1",  obs_err[1],  mdl_err[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
